// File: rtl/score_counter.sv
// -----------------------------------------------------------------------------
// score_counter
//
// Front end of the score display path. Three active-low push buttons
// (player-1 point, player-2 point, clear) are synchronized, debounced and
// falling-edge detected. The resulting one-cycle press strobes drive two
// 2-digit BCD scores and a small game FSM. The game FSM declares the first
// player to reach WIN_SCORE the winner, or a tie when both reach it together.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to accept a
//                    button level change (>= 1)
//   WIN_SCORE        binary score that ends the game (1..99)
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_p1_n   in   player-1 point button, active-low, asynchronous
//   btn_p2_n   in   player-2 point button, active-low, asynchronous
//   btn_clr_n  in   clear button, active-low, asynchronous
//   p1_tens    out  player-1 tens digit, BCD 0..9 (registered)
//   p1_ones    out  player-1 ones digit, BCD 0..9 (registered)
//   p2_tens    out  player-2 tens digit, BCD 0..9 (registered)
//   p2_ones    out  player-2 ones digit, BCD 0..9 (registered)
//   game_over  out  high in any non-PLAY state (registered)
//   winner     out  00 none, 01 player 1, 10 player 2, 11 tie. This is the
//                   FSM state register itself, so it doubles as the state
//                   observation point.
// -----------------------------------------------------------------------------
module score_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIN_SCORE       = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_p1_n,
  input  logic       btn_p2_n,
  input  logic       btn_clr_n,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // WIN_SCORE in the same {tens, ones} BCD form the score registers use,
  // so the win test is a plain equality compare.
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  localparam int BTN_P1  = 0;
  localparam int BTN_P2  = 1;
  localparam int BTN_CLR = 2;

  // State encoding equals the winner output code.
  typedef enum logic [1:0] {
    PLAY   = 2'b00,
    WIN_P1 = 2'b01,
    WIN_P2 = 2'b10,
    TIE    = 2'b11
  } state_t;

  logic [2:0] w_btn_n;
  logic [2:0] w_press;

  assign w_btn_n = {btn_clr_n, btn_p2_n, btn_p1_n};

  // ---------------------------------------------------------------------------
  // Button channels. w_press[g] is a single-cycle strobe with no back-pressure:
  // it is high for exactly one clk cycle after the debounced level falls, and
  // the consumer must act on it in that cycle or lose it. Release produces
  // no strobe.
  // All channel flops reset to the released state, so reset release never
  // fabricates a falling edge.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_deb   <= 1'b1;
        r_deb_d <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn_n[g];
        r_sync2 <= r_sync1;
        r_deb_d <= r_deb;
        if (r_sync2 == r_deb) begin
          // Any agreement restarts the stability window.
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[g] = r_deb_d & ~r_deb;
  end

  // ---------------------------------------------------------------------------
  // Score and game state
  // ---------------------------------------------------------------------------
  logic [7:0] r_p1;
  logic [7:0] r_p2;
  state_t     r_state;
  logic       r_game_over;

  logic [7:0] w_p1_nxt;
  logic [7:0] w_p2_nxt;
  state_t     w_state_nxt;
  logic       w_p1_win;
  logic       w_p2_win;

  // Two-digit BCD increment, {tens, ones}. 99 saturates.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) begin
      return v;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  always_comb begin
    w_p1_nxt    = r_p1;
    w_p2_nxt    = r_p2;
    w_state_nxt = r_state;
    w_p1_win    = 1'b0;
    w_p2_win    = 1'b0;
    if (w_press[BTN_CLR]) begin
      // Clear wins over any point strobe in the same cycle.
      w_p1_nxt    = 8'h00;
      w_p2_nxt    = 8'h00;
      w_state_nxt = PLAY;
    end else if (r_state == PLAY) begin
      if (w_press[BTN_P1]) begin
        w_p1_nxt = bcd_inc(r_p1);
      end
      if (w_press[BTN_P2]) begin
        w_p2_nxt = bcd_inc(r_p2);
      end
      // Only the player who scored this cycle can newly reach WIN_SCORE.
      w_p1_win = w_press[BTN_P1] && (w_p1_nxt == WIN_BCD);
      w_p2_win = w_press[BTN_P2] && (w_p2_nxt == WIN_BCD);
      case ({w_p2_win, w_p1_win})
        2'b11:   w_state_nxt = TIE;
        2'b01:   w_state_nxt = WIN_P1;
        2'b10:   w_state_nxt = WIN_P2;
        default: w_state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1        <= 8'h00;
      r_p2        <= 8'h00;
      r_state     <= PLAY;
      r_game_over <= 1'b0;
    end else begin
      r_p1        <= w_p1_nxt;
      r_p2        <= w_p2_nxt;
      r_state     <= w_state_nxt;
      r_game_over <= (w_state_nxt != PLAY);
    end
  end

  assign p1_tens   = r_p1[7:4];
  assign p1_ones   = r_p1[3:0];
  assign p2_tens   = r_p2[7:4];
  assign p2_ones   = r_p2[3:0];
  assign game_over = r_game_over;
  assign winner    = r_state;

endmodule

// File: tb/tb_score_counter.sv
// -----------------------------------------------------------------------------
// tb_score_counter
//
// Two instances share clock, reset and buttons: dut_a (DEBOUNCE_CYCLES=4,
// WIN_SCORE=21) and dut_b (DEBOUNCE_CYCLES=4, WIN_SCORE=3). A reference model
// tracks each button as "raw sample seen two edges ago" plus a window of the
// last DEB samples. The debounced level flips when the whole window disagrees
// with it. Each game is modelled with integer scores. Both DUTs are compared
// against the model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_score_counter;

  localparam int DEB = 4;

  // ---------------- clock / reset / stimulus ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic btn_p1_n;
  logic btn_p2_n;
  logic btn_clr_n;

  always #5 clk = ~clk;

  logic [3:0] a_p1_tens, a_p1_ones, a_p2_tens, a_p2_ones;
  logic       a_game_over;
  logic [1:0] a_winner;
  logic [3:0] b_p1_tens, b_p1_ones, b_p2_tens, b_p2_ones;
  logic       b_game_over;
  logic [1:0] b_winner;

  score_counter #(.DEBOUNCE_CYCLES(DEB), .WIN_SCORE(21)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_p1_n  (btn_p1_n),
    .btn_p2_n  (btn_p2_n),
    .btn_clr_n (btn_clr_n),
    .p1_tens   (a_p1_tens),
    .p1_ones   (a_p1_ones),
    .p2_tens   (a_p2_tens),
    .p2_ones   (a_p2_ones),
    .game_over (a_game_over),
    .winner    (a_winner)
  );

  score_counter #(.DEBOUNCE_CYCLES(DEB), .WIN_SCORE(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_p1_n  (btn_p1_n),
    .btn_p2_n  (btn_p2_n),
    .btn_clr_n (btn_clr_n),
    .p1_tens   (b_p1_tens),
    .p1_ones   (b_p1_ones),
    .p2_tens   (b_p2_tens),
    .p2_ones   (b_p2_ones),
    .game_over (b_game_over),
    .winner    (b_winner)
  );

  // ---------------- reference model ----------------
  logic m_sync1 [3];
  logic m_sync2 [3];
  logic m_deb   [3];
  bit   m_pend  [3];
  logic s_q     [3][$];
  int   m_p1    [2];
  int   m_p2    [2];
  int   m_st    [2];   // 0 play, 1 p1 won, 2 p2 won, 3 tie
  int   win_score [2] = '{21, 3};

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_sync1[b] = 1'b1;
      m_sync2[b] = 1'b1;
      m_deb[b]   = 1'b1;
      m_pend[b]  = 1'b0;
      s_q[b].delete();
      for (int i = 0; i < DEB; i++) s_q[b].push_back(1'b1);
    end
    for (int g = 0; g < 2; g++) begin
      m_p1[g] = 0;
      m_p2[g] = 0;
      m_st[g] = 0;
    end
  endtask

  task automatic game_step(input int g, input bit e1, input bit e2, input bit ec);
    bit w1;
    bit w2;
    if (ec) begin
      m_p1[g] = 0;
      m_p2[g] = 0;
      m_st[g] = 0;
    end else if (m_st[g] == 0) begin
      if (e1 && m_p1[g] < 99) m_p1[g]++;
      if (e2 && m_p2[g] < 99) m_p2[g]++;
      w1 = e1 && (m_p1[g] == win_score[g]);
      w2 = e2 && (m_p2[g] == win_score[g]);
      if (w1 && w2)  m_st[g] = 3;
      else if (w1)   m_st[g] = 1;
      else if (w2)   m_st[g] = 2;
    end
  endtask

  // One rising clock edge of the model, using the button levels present at it.
  task automatic model_edge();
    logic raw [3];
    logic s;
    bit   all_diff;
    raw[0] = btn_p1_n;
    raw[1] = btn_p2_n;
    raw[2] = btn_clr_n;
    // Press events found at the previous edge take effect at this one.
    for (int g = 0; g < 2; g++) game_step(g, m_pend[0], m_pend[1], m_pend[2]);
    for (int b = 0; b < 3; b++) begin
      m_pend[b]  = 1'b0;
      s          = m_sync2[b];
      m_sync2[b] = m_sync1[b];
      m_sync1[b] = raw[b];
      s_q[b].push_back(s);
      void'(s_q[b].pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < s_q[b].size(); i++)
        if (s_q[b][i] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_deb[b] = ~m_deb[b];
        if (m_deb[b] == 1'b0) m_pend[b] = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("a.p1_tens",   a_p1_tens,            4'(m_p1[0] / 10));
    cmp("a.p1_ones",   a_p1_ones,            4'(m_p1[0] % 10));
    cmp("a.p2_tens",   a_p2_tens,            4'(m_p2[0] / 10));
    cmp("a.p2_ones",   a_p2_ones,            4'(m_p2[0] % 10));
    cmp("a.game_over", {3'b000, a_game_over}, 4'(m_st[0] != 0));
    cmp("a.winner",    {2'b00, a_winner},     4'(m_st[0]));
    cmp("b.p1_tens",   b_p1_tens,            4'(m_p1[1] / 10));
    cmp("b.p1_ones",   b_p1_ones,            4'(m_p1[1] % 10));
    cmp("b.p2_tens",   b_p2_tens,            4'(m_p2[1] / 10));
    cmp("b.p2_ones",   b_p2_ones,            4'(m_p2[1] % 10));
    cmp("b.game_over", {3'b000, b_game_over}, 4'(m_st[1] != 0));
    cmp("b.winner",    {2'b00, b_winner},     4'(m_st[1]));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change only just after a falling edge; outputs are checked on it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input bit p1, input bit p2, input bit clr, input int hold);
    btn_p1_n  = ~p1;
    btn_p2_n  = ~p2;
    btn_clr_n = ~clr;
    repeat (hold) tick();
    btn_p1_n  = 1'b1;
    btn_p2_n  = 1'b1;
    btn_clr_n = 1'b1;
    repeat (12) tick();
  endtask

  // Asynchronous reset assertion in the middle of the low clock phase.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n     = 1'b0;
    btn_p1_n  = 1'b1;
    btn_p2_n  = 1'b1;
    btn_clr_n = 1'b1;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Held p1 button: one press after DEB+2 edges, no repeat while held.
    btn_p1_n = 1'b0;
    repeat (100) tick();
    cmp("held_once", a_p1_ones, 4'd1);
    btn_p1_n = 1'b1;
    repeat (20) tick();

    // Short p2 glitches (1, 2, 3 cycles) must be rejected.
    for (int w = 1; w <= 3; w++) begin
      btn_p2_n = 1'b0;
      repeat (w) tick();
      btn_p2_n = 1'b1;
      repeat (10) tick();
    end
    cmp("glitch_p2", a_p2_ones, 4'd0);

    // Nine more p1 presses: 9 -> 10 carry.
    repeat (9) press(1, 0, 0, 8);
    cmp("carry_tens", a_p1_tens, 4'd1);
    cmp("carry_ones", a_p1_ones, 4'd0);

    // Up to 21: dut_a declares player 1, then freezes.
    repeat (11) press(1, 0, 0, 8);
    cmp("win_p1_winner", {2'b00, a_winner}, 4'd1);
    repeat (3) press(1, 0, 0, 8);
    repeat (3) press(0, 1, 0, 8);
    cmp("frozen_p1", a_p1_ones, 4'd1);
    cmp("frozen_p2", a_p2_ones, 4'd0);

    // Clear, then tie on dut_b (WIN_SCORE 3) via coincident presses.
    press(0, 0, 1, 8);
    repeat (2) press(1, 0, 0, 8);
    repeat (2) press(0, 1, 0, 8);
    press(1, 1, 0, 8);
    cmp("tie_winner", {2'b00, b_winner}, 4'd3);
    cmp("tie_game_over", {3'b000, b_game_over}, 4'd1);

    // Clear and p1 press coincide at 20: clear wins.
    press(0, 0, 1, 8);
    repeat (20) press(1, 0, 0, 8);
    press(1, 0, 1, 8);
    cmp("clr_prio_ones", a_p1_ones, 4'd0);
    cmp("clr_prio_tens", a_p1_tens, 4'd0);

    // Reset mid-game at 15/12 with p1 mid-debounce, button released in reset.
    repeat (15) press(1, 0, 0, 8);
    repeat (12) press(0, 1, 0, 8);
    btn_p1_n = 1'b0;
    repeat (3) tick();
    async_reset();
    btn_p1_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    cmp("no_stale_inc", a_p1_ones, 4'd0);

    // Button held through reset release counts once.
    btn_p1_n = 1'b0;
    repeat (2) tick();
    async_reset();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    btn_p1_n = 1'b1;
    repeat (12) tick();
    cmp("held_thru_reset", a_p1_ones, 4'd1);

    // Random button activity, including glitches and rare clears.
    repeat (300) begin
      btn_p1_n  = 1'($urandom_range(0, 1));
      btn_p2_n  = 1'($urandom_range(0, 1));
      btn_clr_n = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 10)) tick();
    end
    btn_p1_n  = 1'b1;
    btn_p2_n  = 1'b1;
    btn_clr_n = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
